// File: rtl/time_set_core.sv
// Timekeeping and time-setting datapath: counts HH:MM:SS from a prescaled tick in NORMAL
// mode and steps the selected field from the increment button in the setting modes.
module time_set_core #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] mode,
    input  logic       inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       tick,
    output logic [2:0] sel,
    output logic       blink
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_SEC    = 2'b01,
        MODE_MIN    = 2'b10,
        MODE_HOUR   = 2'b11
    } mode_t;

    logic [1:0]    mode_meta;
    mode_t         mode_s;
    logic          inc_meta, inc_sync, inc_prev, inc_pulse;
    logic [TW-1:0] presc, presc_nx;
    logic [BW-1:0] bcnt, bcnt_nx;
    logic          blink_ph, blink_ph_nx;
    logic [5:0]    sec_nx, min_nx;
    logic [4:0]    hour_nx;
    logic          tick_nx;
    logic [5:0]    sec_inc, min_inc;
    logic [4:0]    hour_inc;

    assign inc_pulse = inc_sync & ~inc_prev;

    // Wrapping increments; the >= compares keep every field in range even from a corrupt value.
    assign sec_inc  = (sec  >= 6'd59) ? 6'd0 : sec  + 6'd1;
    assign min_inc  = (min  >= 6'd59) ? 6'd0 : min  + 6'd1;
    assign hour_inc = (hour >= 5'd23) ? 5'd0 : hour + 5'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_meta <= 2'b00;
            mode_s    <= MODE_NORMAL;
            inc_meta  <= 1'b0;
            inc_sync  <= 1'b0;
            inc_prev  <= 1'b0;
            presc     <= '0;
            bcnt      <= '0;
            blink_ph  <= 1'b0;
            sec       <= 6'd0;
            min       <= 6'd0;
            hour      <= 5'd0;
            tick      <= 1'b0;
        end else begin
            mode_meta <= mode;
            mode_s    <= mode_t'(mode_meta);
            inc_meta  <= inc;
            inc_sync  <= inc_meta;
            inc_prev  <= inc_sync;
            presc     <= presc_nx;
            bcnt      <= bcnt_nx;
            blink_ph  <= blink_ph_nx;
            sec       <= sec_nx;
            min       <= min_nx;
            hour      <= hour_nx;
            tick      <= tick_nx;
        end
    end

    always_comb begin
        presc_nx    = presc;
        bcnt_nx     = bcnt;
        blink_ph_nx = blink_ph;
        sec_nx      = sec;
        min_nx      = min;
        hour_nx     = hour;
        tick_nx     = 1'b0;

        if (mode_s == MODE_NORMAL) begin
            bcnt_nx     = '0;
            blink_ph_nx = 1'b0;
            if (presc == TICK_LAST) begin
                presc_nx = '0;
                tick_nx  = 1'b1;
                sec_nx   = sec_inc;
                if (sec >= 6'd59) begin
                    min_nx = min_inc;
                    if (min >= 6'd59) begin
                        hour_nx = hour_inc;
                    end
                end
            end else begin
                presc_nx = presc + TW'(1);
            end
        end else begin
            // Timekeeping frozen; the prescaler sits at 0 so NORMAL resumes with a full second.
            presc_nx = '0;
            if (bcnt == BLINK_LAST) begin
                bcnt_nx     = '0;
                blink_ph_nx = ~blink_ph;
            end else begin
                bcnt_nx = bcnt + BW'(1);
            end
            if (inc_pulse) begin
                case (mode_s)
                    MODE_SEC:  sec_nx  = sec_inc;
                    MODE_MIN:  min_nx  = min_inc;
                    MODE_HOUR: hour_nx = hour_inc;
                    default:   sec_nx  = sec;
                endcase
            end
        end
    end

    always_comb begin
        sel = 3'b000;
        case (mode_s)
            MODE_SEC:  sel = 3'b001;
            MODE_MIN:  sel = 3'b010;
            MODE_HOUR: sel = 3'b100;
            default:   sel = 3'b000;
        endcase
    end

    assign blink = blink_ph & (mode_s != MODE_NORMAL);

endmodule

// File: tb/tb_time_set_core.sv
// Directed self-checking bench for time_set_core with TICK_DIV=4 and BLINK_DIV=2.
module tb_time_set_core;

    logic       clk;
    logic       reset_n;
    logic [1:0] mode;
    logic       inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick;
    logic [2:0] sel;
    logic       blink;

    int checkCount = 0;
    int passCount  = 0;

    time_set_core #(
        .TICK_DIV (4),
        .BLINK_DIV(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .mode   (mode),
        .inc    (inc),
        .sec    (sec),
        .min    (min),
        .hour   (hour),
        .tick   (tick),
        .sel    (sel),
        .blink  (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Enter a setting mode, let the synchronizer settle, then give a number of clean presses.
    task automatic applyStimulus(input logic [1:0] m, input int presses);
        mode = m;
        waitEdges(3);
        for (int p = 0; p < presses; p++) begin
            inc = 1'b1;
            waitEdges(2);
            inc = 1'b0;
            waitEdges(2);
        end
        waitEdges(2);
    endtask

    initial begin
        reset_n = 1'b0;
        mode    = 2'b00;
        inc     = 1'b0;

        // Reset state, then reset asserted mid-count
        waitEdges(2);
        checkOutput("rst_sec", sec, 0);
        checkOutput("rst_sel", sel, 0);
        reset_n = 1'b1;
        waitEdges(6);
        checkOutput("pre_reset_sec", sec, 1);
        reset_n = 1'b0;
        #2;
        checkOutput("midrst_sec", sec, 0);
        checkOutput("midrst_min", min, 0);
        checkOutput("midrst_hour", hour, 0);
        checkOutput("midrst_tick", tick, 0);
        checkOutput("midrst_sel", sel, 0);
        checkOutput("midrst_blink", blink, 0);
        waitEdges(1);
        reset_n = 1'b1;
        waitEdges(3);
        checkOutput("run_tick_early", tick, 0);
        checkOutput("run_sec_early", sec, 0);
        waitEdges(1);
        checkOutput("run_tick_first", tick, 1);
        checkOutput("run_sec_first", sec, 1);
        waitEdges(1);
        checkOutput("run_tick_pulse", tick, 0);
        waitEdges(7);
        checkOutput("run_sec_12", sec, 3);
        checkOutput("run_tick_12", tick, 1);

        // Preset 23:59:58 through the setting modes
        applyStimulus(2'b11, 23);
        checkOutput("set_hour", hour, 23);
        checkOutput("set_sel_hour", sel, 3'b100);
        applyStimulus(2'b10, 59);
        checkOutput("set_min", min, 59);
        checkOutput("set_hour_hold", hour, 23);
        applyStimulus(2'b01, 55);
        checkOutput("set_sec", sec, 58);
        checkOutput("set_min_hold", min, 59);
        checkOutput("set_sel_sec", sel, 3'b001);
        checkOutput("set_tick", tick, 0);

        // Rollover in NORMAL
        mode = 2'b00;
        waitEdges(2);
        checkOutput("roll_sel", sel, 0);
        checkOutput("roll_blink", blink, 0);
        waitEdges(3);
        checkOutput("roll_sec58", sec, 58);
        checkOutput("roll_tick_a0", tick, 0);
        waitEdges(1);
        checkOutput("roll_sec59", sec, 59);
        checkOutput("roll_tick_a1", tick, 1);
        checkOutput("roll_hour23", hour, 23);
        waitEdges(3);
        checkOutput("roll_tick_b0", tick, 0);
        waitEdges(1);
        checkOutput("roll_tick_b1", tick, 1);
        checkOutput("roll_sec0", sec, 0);
        checkOutput("roll_min0", min, 0);
        checkOutput("roll_hour0", hour, 0);

        // Minutes to 59, then one held press wraps without carry
        applyStimulus(2'b10, 59);
        checkOutput("inc_min59", min, 59);
        checkOutput("inc_hour0", hour, 0);
        checkOutput("inc_sec0", sec, 0);
        inc = 1'b1;
        waitEdges(2);
        checkOutput("inc_min_edge2", min, 59);
        waitEdges(1);
        checkOutput("inc_min_edge3", min, 0);
        checkOutput("inc_hour_nocarry", hour, 0);
        checkOutput("inc_sel", sel, 3'b010);
        waitEdges(7);
        checkOutput("inc_held_min", min, 0);
        checkOutput("inc_held_sec", sec, 0);
        inc = 1'b0;
        waitEdges(4);
        checkOutput("inc_release_min", min, 0);

        // HOURS back to NORMAL
        mode = 2'b11;
        waitEdges(2);
        checkOutput("ret_sel_hour", sel, 3'b100);
        mode = 2'b00;
        waitEdges(1);
        checkOutput("ret_sel_still", sel, 3'b100);
        waitEdges(1);
        checkOutput("ret_sel_norm", sel, 0);
        checkOutput("ret_blink", blink, 0);
        waitEdges(3);
        checkOutput("ret_tick_early", tick, 0);
        checkOutput("ret_sec_early", sec, 0);
        waitEdges(1);
        checkOutput("ret_tick_first", tick, 1);
        checkOutput("ret_sec_first", sec, 1);

        // Freeze in SECONDS mode with blink running
        mode = 2'b01;
        waitEdges(2);
        checkOutput("frz_sel", sel, 3'b001);
        checkOutput("frz_blink_entry", blink, 0);
        for (int i = 1; i <= 20; i++) begin
            waitEdges(1);
            checkOutput($sformatf("frz_tick_%0d", i), tick, 0);
            checkOutput($sformatf("frz_blink_%0d", i), blink, (i / 2) % 2);
        end
        checkOutput("frz_sec", sec, 1);
        checkOutput("frz_min", min, 0);
        checkOutput("frz_hour", hour, 0);

        // Press arriving together with the SECONDS to MINUTES change
        mode = 2'b10;
        inc  = 1'b1;
        waitEdges(3);
        checkOutput("coin_min", min, 1);
        checkOutput("coin_sec", sec, 1);
        checkOutput("coin_sel", sel, 3'b010);
        inc = 1'b0;
        waitEdges(3);
        checkOutput("coin_min_hold", min, 1);
        checkOutput("coin_sec_hold", sec, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
